spi_slave_tx: RTL and testbench

//  SPI mode-0 slave transmitter; the MISO-side counterpart of the spi_slave receiver.
//  It accepts a byte from local logic over a valid/ready handshake and holds it in a 1-entry buffer.
//  On each frame (cs low) it shifts the byte out MSB-first on miso, driven by the master's fsm_spi sclk/cs.

---
 rtl/spi_slave_tx.sv | 144 ++++++++++++++
 tb/tb_spi_slave_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: 1-entry holding buffer, MSB-first shift
// out on miso, with sclk/cs oversampled in the clk domain.
module spi_slave_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              sclk,
  input  logic              cs,
  output logic              miso,
  output logic              miso_oe,
  output logic              tx_done,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              done_q, done_d;
  logic              unr_q, unr_d;
  logic              accept;

  // cs chain resets to deasserted so reset release never looks like a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  assign tx_ready = ~hold_full_q;
  assign accept   = tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    unr_d       = 1'b0;
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            shift_d = '0;
            unr_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (sclk_fall && bit_cnt_q < CNT_MAX) begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      unr_q       <= unr_d;
    end
  end

  assign miso     = (state_q == SHIFT) & shift_q[DATA_W-1];
  assign miso_oe  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign underrun = unr_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: a mode-0 master model shifts frames
// and compares received bits and pulse counts against hand values.
module tb_spi_slave_tx;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sclk;
  logic       cs;
  logic       miso;
  logic       miso_oe;
  logic       tx_done;
  logic       underrun;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int unr_cnt  = 0;

  localparam int HALF = 6;

  spi_slave_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sclk     (sclk),
    .cs       (cs),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_done  (tx_done),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (underrun) unr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int budget;
    budget = 200;
    while (!tx_ready && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("push_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic frame(input int nbits, output logic [15:0] got,
                       output logic oe_mid);
    got    = '0;
    oe_mid = 1'b0;
    cs = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      got  = {got[14:0], miso};
      if (i == 0) oe_mid = miso_oe;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
      tick(HALF);
    end
    cs = 1'b1;
    tick(HALF + 2);
  endtask

  logic [15:0] got;
  logic        oe;
  int          d0;
  int          u0;

  initial begin
    rst      = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    sclk     = 1'b0;
    cs       = 1'b1;
    tick(3);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_unr", {31'd0, underrun}, 32'd0);
    rst = 1'b1;
    tick(3);

    // reset asserted in the middle of a frame
    push(8'hA5);
    cs = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
    tick(HALF);
    chk("mid_oe", {31'd0, miso_oe}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rmid_ready", {31'd0, tx_ready}, 32'd1);
    chk("rmid_miso", {31'd0, miso}, 32'd0);
    chk("rmid_oe", {31'd0, miso_oe}, 32'd0);
    chk("rmid_done", {31'd0, tx_done}, 32'd0);
    chk("rmid_unr", {31'd0, underrun}, 32'd0);
    cs = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(4);

    // plain A5 frame
    d0 = done_cnt;
    u0 = unr_cnt;
    push(8'hA5);
    chk("a5_ready_full", {31'd0, tx_ready}, 32'd0);
    frame(8, got, oe);
    chk("a5_bits", {16'd0, got}, 32'h00A5);
    chk("a5_oe", {31'd0, oe}, 32'd1);
    chk("a5_done", done_cnt - d0, 32'd1);
    chk("a5_unr", unr_cnt - u0, 32'd0);
    chk("a5_ready", {31'd0, tx_ready}, 32'd1);
    chk("a5_oe_after", {31'd0, miso_oe}, 32'd0);

    // lookahead: refill buffer while a frame is in flight
    d0 = done_cnt;
    u0 = unr_cnt;
    push(8'h3C);
    fork
      frame(8, got, oe);
      begin
        tick(8);
        push(8'hC3);
      end
    join
    chk("la_first", {16'd0, got}, 32'h003C);
    chk("la_full", {31'd0, tx_ready}, 32'd0);
    frame(8, got, oe);
    chk("la_second", {16'd0, got}, 32'h00C3);
    chk("la_done", done_cnt - d0, 32'd2);
    chk("la_unr", unr_cnt - u0, 32'd0);

    // empty buffer at frame start
    d0 = done_cnt;
    u0 = unr_cnt;
    frame(8, got, oe);
    chk("ur_bits", {16'd0, got}, 32'h0000);
    chk("ur_unr", unr_cnt - u0, 32'd1);
    chk("ur_done", done_cnt - d0, 32'd1);

    // aborted frame after 4 bits
    d0 = done_cnt;
    u0 = unr_cnt;
    push(8'hFF);
    frame(4, got, oe);
    chk("ab_bits", {16'd0, got}, 32'h000F);
    chk("ab_done", done_cnt - d0, 32'd0);
    chk("ab_oe", {31'd0, miso_oe}, 32'd0);
    chk("ab_ready", {31'd0, tx_ready}, 32'd1);
    push(8'h5A);
    frame(8, got, oe);
    chk("ab_next", {16'd0, got}, 32'h005A);
    chk("ab_next_done", done_cnt - d0, 32'd1);
    chk("ab_unr", unr_cnt - u0, 32'd0);

    // overlong frame: extra clocks read zero, no wrap
    d0 = done_cnt;
    push(8'h81);
    frame(10, got, oe);
    chk("ol_bits", {16'd0, got}, 32'h0204);
    chk("ol_done", done_cnt - d0, 32'd1);
    chk("ol_ready", {31'd0, tx_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
